instr_fetch: RTL and testbench

- Instruction-fetch initiator for the 16-bit Thumb-style CPU.
- Drives the synchronous single-port `memory` read interface (addr/en/rd_en/wr_en, one-cycle read latency).
- Buffers returned halfwords in a small prefetch FIFO and hands them to `fetch_decode` over a valid/ready handshake.
- Accepts branch redirects from execute and discards stale in-flight data.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 35 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   MEM_DEPTH / ADDR_WIDTH : default instruction memory geometry (16-bit words)
//   instr_t                : one Thumb-style halfword instruction
//   fetch_entry_t          : prefetch buffer entry (instruction + byte PC)
package fetch_pkg;

  localparam int MEM_DEPTH  = 4096;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef logic [15:0] instr_t;

  typedef struct packed {
    instr_t                instr;
    logic [ADDR_WIDTH:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   fetch_en, redirect_valid, redirect_addr : control from core / execute
//   mem_addr, mem_en, mem_rd_en, mem_wr_en  : read port to synchronous memory
//   mem_rdata                               : memory dout, one cycle after strobe
//   instr, instr_pc, instr_valid            : decode-side output, valid/ready
//   instr_ready                             : decode accepts instr
// Modports: master = fetch unit, slave = environment (memory + decode + execute).
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = fetch_pkg::ADDR_WIDTH
);

  logic                  fetch_en;
  logic                  redirect_valid;
  logic [ADDR_WIDTH:0]   redirect_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  fetch_pkg::instr_t     mem_rdata;
  fetch_pkg::instr_t     instr;
  logic [ADDR_WIDTH:0]   instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    input  fetch_en, redirect_valid, redirect_addr, mem_rdata, instr_ready,
    output mem_addr, mem_en, mem_rd_en, mem_wr_en, instr, instr_pc, instr_valid
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_addr, mem_rdata, instr_ready,
    input  mem_addr, mem_en, mem_rd_en, mem_wr_en, instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small power-of-two circular FIFO of fetch entries.
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, push_data : write an entry at the tail
//   pop, pop_data   : advance the head; pop_data always shows the head entry
//   flush           : empty the buffer, overriding push and pop
//   count, full, empty : occupancy status
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator for the 16-bit Thumb-style CPU.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : instr_fetch_if.master -- memory read port, decode valid/ready
//              output, fetch_en and branch redirect inputs
// Optional build macro INSTR_FETCH_PERF_CNT_EN adds saturating counters:
//   perf_issue_cnt : issued memory reads
//   perf_flush_cnt : words discarded by redirects (buffered + in flight)
//   perf_stall_cnt : cycles with instr_valid && !instr_ready
// Reads are credit-limited so every returning word has a buffer slot; a word
// popped in the same cycle frees its slot early to sustain 1 instr/cycle.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH  = fetch_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_issue_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RESET_PTR = ADDR_WIDTH'(RESET_ADDR >> 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef struct packed {
    instr_t              instr;
    logic [ADDR_WIDTH:0] pc;
  } entry_t;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [CW:0]           used;
  logic                  issue;
  logic                  push_ok;
  logic                  pop_ok;
  entry_t                push_entry;
  entry_t                head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  unused_addr_bit0;

  assign redirect         = bus.redirect_valid;
  assign target           = bus.redirect_addr[ADDR_WIDTH:1];
  assign unused_addr_bit0 = bus.redirect_addr[0];

  // Stage p0: credit check, read issue and fetch pointer update
  always_comb begin
    pop_ok      = !fifo_empty && bus.instr_ready && !redirect;
    used        = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1_q} - {{CW{1'b0}}, pop_ok};
    issue       = !rst && bus.fetch_en && (redirect || (used < DEPTH_W));
    issue_addr  = redirect ? target : fetch_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    if (redirect)   fetch_ptr_d = issue ? ptr_inc(target) : target;
    else if (issue) fetch_ptr_d = ptr_inc(fetch_ptr_q);
    vld_p1_d    = issue;
    addr_p1_d   = issue_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr_q <= RESET_PTR;
      vld_p1_q    <= 1'b0;
    end else begin
      fetch_ptr_q <= fetch_ptr_d;
      vld_p1_q    <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1_q <= addr_p1_d;
  end

  assign bus.mem_addr  = issue_addr;
  assign bus.mem_en    = issue;
  assign bus.mem_rd_en = issue;
  assign bus.mem_wr_en = 1'b0;

  // Stage p1: memory data returns and is written into the prefetch buffer
  always_comb begin
    push_ok          = vld_p1_q && !redirect && (!fifo_full || pop_ok);
    push_entry.instr = bus.mem_rdata;
    push_entry.pc    = {addr_p1_q, 1'b0};
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop_ok),
    .flush     (redirect),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stage p2: buffer head presented to decode
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? '0 : head.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

`ifdef INSTR_FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = sat_add(issue_cnt_q, 32'(issue));
    flush_cnt_d = flush_cnt_q;
    if (redirect) flush_cnt_d = sat_add(flush_cnt_q, 32'(fifo_count) + 32'(vld_p1_q));
    stall_cnt_d = sat_add(stall_cnt_q, 32'(!fifo_empty && !bus.instr_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch.
// DUT A: default geometry, FIFO_DEPTH=2, RESET_ADDR=0.
// DUT B: FIFO_DEPTH=4, RESET_ADDR=0x1FFC (address wrap, 3-word flush).
// Memory model: word w holds 0x2001 + w, returned one cycle after the strobe.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic mon_a  = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(12)) ifa ();
  instr_fetch_if #(.ADDR_WIDTH(12)) ifb ();

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] pa_issue, pa_flush, pa_stall;
  logic [31:0] pb_issue, pb_flush, pb_stall;
`endif

  instr_fetch #(.MEM_DEPTH(4096), .ADDR_WIDTH(12), .FIFO_DEPTH(2), .RESET_ADDR(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
`ifdef INSTR_FETCH_PERF_CNT_EN
    , .perf_issue_cnt (pa_issue), .perf_flush_cnt (pa_flush), .perf_stall_cnt (pa_stall)
`endif
  );

  instr_fetch #(.MEM_DEPTH(4096), .ADDR_WIDTH(12), .FIFO_DEPTH(4), .RESET_ADDR(32'h1FFC)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
`ifdef INSTR_FETCH_PERF_CNT_EN
    , .perf_issue_cnt (pb_issue), .perf_flush_cnt (pb_flush), .perf_stall_cnt (pb_stall)
`endif
  );

  function automatic logic [15:0] mval(input logic [11:0] w);
    return 16'h2001 + {4'h0, w};
  endfunction

  always @(posedge clk) begin
    if (ifa.mem_en && ifa.mem_rd_en) ifa.mem_rdata <= mval(ifa.mem_addr);
    if (ifb.mem_en && ifb.mem_rd_en) ifb.mem_rdata <= mval(ifb.mem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for DUT A: expected delivery stream, popped on each transfer.
  typedef struct packed {
    logic [15:0] instr;
    logic [12:0] pc;
  } exp_t;
  exp_t qa[$];

  task automatic sb_reload(input logic [12:0] pc0);
    logic [12:0] p;
    qa.delete();
    p = pc0;
    for (int i = 0; i < 64; i++) begin
      qa.push_back('{instr: mval(p[12:1]), pc: p});
      p = p + 13'd2;
    end
  endtask

  always @(negedge clk) begin
    if (mon_a && !rst_a && !ifa.redirect_valid && ifa.instr_valid && ifa.instr_ready) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: unexpected transfer pc 0x%0h", ifa.instr_pc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("sb_instr", 32'(ifa.instr), 32'(e.instr));
        chk("sb_pc", 32'(ifa.instr_pc), 32'(e.pc));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  typedef struct {
    logic [12:0] raddr;
    logic [11:0] exp_maddr;
    logic [12:0] exp_pc;
  } redir_vec_t;

  typedef struct {
    logic [12:0] pc;
    logic [15:0] instr;
  } wrap_vec_t;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1, "timeout");
  end

  initial begin
    redir_vec_t rv[3];
    wrap_vec_t  wv[4];
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] flush_before;
`endif
    rv[0] = '{raddr: 13'h0200, exp_maddr: 12'h100, exp_pc: 13'h0200};
    rv[1] = '{raddr: 13'h0041, exp_maddr: 12'h020, exp_pc: 13'h0040};
    rv[2] = '{raddr: 13'h1FFE, exp_maddr: 12'hFFF, exp_pc: 13'h1FFE};
    wv[0] = '{pc: 13'h1FFC, instr: 16'h2FFF};
    wv[1] = '{pc: 13'h1FFE, instr: 16'h3000};
    wv[2] = '{pc: 13'h0000, instr: 16'h2001};
    wv[3] = '{pc: 13'h0002, instr: 16'h2002};

    rst_a = 1'b1;  rst_b = 1'b1;
    ifa.fetch_en = 1'b1; ifa.instr_ready = 1'b1; ifa.redirect_valid = 1'b0; ifa.redirect_addr = '0;
    ifb.fetch_en = 1'b1; ifb.instr_ready = 1'b1; ifb.redirect_valid = 1'b0; ifb.redirect_addr = '0;

    // Reset values
    repeat (3) nxt();
    mid();
    chk("rst_valid", 32'(ifa.instr_valid), 0);
    chk("rst_instr", 32'(ifa.instr), 0);
    chk("rst_pc", 32'(ifa.instr_pc), 0);
    chk("rst_mem_en", 32'(ifa.mem_en), 0);
    chk("rst_rd_en", 32'(ifa.mem_rd_en), 0);
    chk("rst_wr_en", 32'(ifa.mem_wr_en), 0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("rst_perf_issue", pa_issue, 0);
    chk("rst_perf_flush", pa_flush, 0);
    chk("rst_perf_stall", pa_stall, 0);
`endif

    // First fetch after reset release: valid two cycles later
    nxt();
    rst_a = 1'b0;
    sb_reload(13'h0000);
    mon_a = 1'b1;
    mid();
    chk("first_mem_en", 32'(ifa.mem_en), 1);
    chk("first_mem_addr", 32'(ifa.mem_addr), 0);
    nxt(); mid();
    chk("first_valid_n1", 32'(ifa.instr_valid), 0);
    nxt(); mid();
    chk("first_valid_n2", 32'(ifa.instr_valid), 1);
    chk("first_instr", 32'(ifa.instr), 32'h2001);
    chk("first_pc", 32'(ifa.instr_pc), 0);
    for (int i = 0; i < 6; i++) begin
      nxt(); mid();
      chk("stream_valid", 32'(ifa.instr_valid), 1);
    end

    // Decode stall for 6 cycles: head held, reads stop when credit is exhausted
    nxt();
    ifa.instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("stall_valid", 32'(ifa.instr_valid), 1);
      chk("stall_instr", 32'(ifa.instr), 32'(qa[0].instr));
      chk("stall_pc", 32'(ifa.instr_pc), 32'(qa[0].pc));
      if (i >= 1) chk("stall_rd_en", 32'(ifa.mem_rd_en), 0);
      nxt();
    end
    ifa.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("resume_valid", 32'(ifa.instr_valid), 1);
      nxt();
    end

    // Redirect table
    for (int v = 0; v < 3; v++) begin
      ifa.redirect_valid = 1'b1;
      ifa.redirect_addr  = rv[v].raddr;
      sb_reload(rv[v].exp_pc);
      mid();
      chk("redir_mem_addr", 32'(ifa.mem_addr), 32'(rv[v].exp_maddr));
      chk("redir_mem_en", 32'(ifa.mem_en), 1);
      nxt();
      ifa.redirect_valid = 1'b0;
      mid();
      chk("redir_valid_r1", 32'(ifa.instr_valid), 0);
      nxt(); mid();
      chk("redir_valid_r2", 32'(ifa.instr_valid), 1);
      chk("redir_pc_r2", 32'(ifa.instr_pc), 32'(rv[v].exp_pc));
      repeat (3) nxt();
    end

    // One-cycle reset pulse while streaming
    rst_a = 1'b1;
    mid();
    chk("rstpulse_mem_en", 32'(ifa.mem_en), 0);
    nxt();
    rst_a = 1'b0;
    sb_reload(13'h0000);
    mid();
    chk("rstpulse_valid_n0", 32'(ifa.instr_valid), 0);
    chk("rstpulse_mem_addr", 32'(ifa.mem_addr), 0);
    chk("rstpulse_mem_en", 32'(ifa.mem_en), 1);
    nxt(); mid();
    chk("rstpulse_valid_n1", 32'(ifa.instr_valid), 0);
    nxt(); mid();
    chk("rstpulse_valid_n2", 32'(ifa.instr_valid), 1);
    chk("rstpulse_pc", 32'(ifa.instr_pc), 0);
    chk("rstpulse_instr", 32'(ifa.instr), 32'h2001);
    repeat (3) nxt();

    // fetch_en=0 with a read in flight: that word still arrives, then nothing
    ifa.fetch_en = 1'b0;
    mid();
    chk("fen0_mem_en_0", 32'(ifa.mem_en), 0);
    chk("fen0_valid_0", 32'(ifa.instr_valid), 1);
    nxt(); mid();
    chk("fen0_mem_en_1", 32'(ifa.mem_en), 0);
    chk("fen0_inflight_valid", 32'(ifa.instr_valid), 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("fen0_idle_valid", 32'(ifa.instr_valid), 0);
      chk("fen0_idle_mem_en", 32'(ifa.mem_en), 0);
      nxt();
    end
    ifa.fetch_en = 1'b1;
    mid();
    chk("fen1_mem_en", 32'(ifa.mem_en), 1);
    nxt(); mid();
    chk("fen1_valid_1", 32'(ifa.instr_valid), 0);
    nxt(); mid();
    chk("fen1_valid_2", 32'(ifa.instr_valid), 1);
    repeat (3) nxt();
    mon_a = 1'b0;

    // DUT B: reset address near top of memory, pointer wraps to 0
    rst_b = 1'b0;
    mid();
    chk("wrap_mem_addr", 32'(ifb.mem_addr), 32'h0FFE);
    nxt(); nxt();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("wrap_valid", 32'(ifb.instr_valid), 1);
      chk("wrap_pc", 32'(ifb.instr_pc), 32'(wv[k].pc));
      chk("wrap_instr", 32'(ifb.instr), 32'(wv[k].instr));
      nxt();
    end

    // DUT B: redirect with 2 words buffered and 1 in flight
    rst_b = 1'b1;
    ifb.instr_ready = 1'b0;
    nxt();
    rst_b = 1'b0;
    nxt(); nxt(); nxt();
    ifb.redirect_valid = 1'b1;
    ifb.redirect_addr  = 13'h0200;
    mid();
    chk("b_redir_mem_addr", 32'(ifb.mem_addr), 32'h0100);
    chk("b_redir_valid", 32'(ifb.instr_valid), 1);
`ifdef INSTR_FETCH_PERF_CNT_EN
    flush_before = pb_flush;
`endif
    nxt();
    ifb.redirect_valid = 1'b0;
    ifb.instr_ready    = 1'b1;
    mid();
    chk("b_redir_valid_r1", 32'(ifb.instr_valid), 0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("b_perf_flush_delta", pb_flush - flush_before, 3);
    chk("b_perf_issue", pb_issue, 4);
    chk("b_perf_stall", pb_stall, 2);
`endif
    nxt(); mid();
    chk("b_redir_valid_r2", 32'(ifb.instr_valid), 1);
    chk("b_redir_pc", 32'(ifb.instr_pc), 32'h0200);
    chk("b_redir_instr", 32'(ifb.instr), 32'h2101);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
